// File: rtl/adc_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_pkg
// Description : Shared types and constants for the ADC conversion sequencer.
//               Holds the FSM state enum, APB register word offsets and the
//               CTRL/STATUS bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_CONV  = 2'd2
    } state_t;

    // Register word offsets as seen on PADDR[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PERIOD = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_DATA   = 3'd3;
    localparam logic [2:0] REG_COUNT  = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_PID_EN  = 2;

    // STATUS bit positions
    localparam int STAT_BUSY     = 0;
    localparam int STAT_OVERRUN  = 1;
    localparam int STAT_TIMEOUT  = 2;
    localparam int STAT_DVALID   = 3;
    localparam int STAT_PID_DROP = 4;

endpackage
`default_nettype wire

// File: rtl/adc_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_timer
// Description : Period down-counter. Loaded with PERIOD when enable rises,
//               then counts down while enabled; emits a one-cycle tick at zero
//               and reloads, giving one tick every PERIOD+1 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_seq_timer
    import adc_seq_pkg::*;
#(
    parameter int PER_W = 16
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [PER_W-1:0] i_period,
    output logic             o_tick
);

    logic [PER_W-1:0] r_cnt;

    // Tick is combinational so the trigger lands in the same cycle the count hits zero
    assign o_tick = i_en && (r_cnt == '0);

    // Down-counter: load on enable rise, reload at zero, frozen while disabled
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_period;
        end else if (i_en) begin
            if (r_cnt == '0) begin
                r_cnt <= i_period;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_seq_ctrl
// Description : APB-programmable ADC conversion sequencer. Issues periodic or
//               one-shot conversion starts, waits for the converter done strobe
//               with a timeout, latches results for readback and forwards them
//               to the PID loop over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int DATA_W  = 12,
    parameter int PER_W   = 16,
    parameter int TMO_CYC = 255
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic              adc_start,
    input  logic              adc_done,
    input  logic [DATA_W-1:0] adc_data,
    output logic              pid_valid,
    output logic [DATA_W-1:0] pid_data,
    input  logic              pid_ready
);

    localparam logic [7:0] c_tmo_max = 8'(TMO_CYC);

    state_t              r_state;
    logic                r_adc_start;
    logic [7:0]          r_tmo;
    logic                r_en;
    logic                r_pid_en;
    logic [PER_W-1:0]    r_period;
    logic                r_overrun;
    logic                r_timeout;
    logic                r_dvalid;
    logic                r_pid_drop;
    logic [DATA_W-1:0]   r_data;
    logic [15:0]         r_count;
    logic                r_pid_valid;
    logic [DATA_W-1:0]   r_pid_data;

    logic [2:0] w_idx;
    logic       w_wr, w_rd, w_wr_ctrl, w_wr_stat;
    logic       w_load, w_oneshot, w_tick, w_trigger;
    logic       w_sample, w_timeout, w_overrun, w_push, w_drop;
    logic       w_unused;

    assign w_idx     = PADDR[4:2];
    assign w_wr      = PSEL && PENABLE && PWRITE;
    assign w_rd      = PSEL && PENABLE && !PWRITE;
    assign w_wr_ctrl = w_wr && (w_idx == REG_CTRL);
    assign w_wr_stat = w_wr && (w_idx == REG_STATUS);

    // Timer reload only on a 0->1 transition of en
    assign w_load    = w_wr_ctrl && PWDATA[CTRL_EN] && !r_en;
    assign w_oneshot = w_wr_ctrl && PWDATA[CTRL_ONESHOT];
    assign w_trigger = w_tick || w_oneshot;

    assign w_sample  = (r_state == S_CONV) && adc_done;
    assign w_timeout = (r_state == S_CONV) && !adc_done && (r_tmo == c_tmo_max);
    assign w_overrun = w_trigger && (r_state != S_IDLE);
    assign w_push    = w_sample && r_pid_en;
    assign w_drop    = w_push && r_pid_valid && !pid_ready;

    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign adc_start = r_adc_start;
    assign pid_valid = r_pid_valid;
    assign pid_data  = r_pid_data;

    assign w_unused  = &{1'b0, PADDR[31:5], PADDR[1:0], PWDATA[31:PER_W]};

    adc_seq_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .PCLK     (PCLK),
        .PRESETn  (PRESETn),
        .i_en     (r_en),
        .i_load   (w_load),
        .i_period (r_period),
        .o_tick   (w_tick)
    );

    // Sequencer FSM: one-cycle start pulse, then wait for done or timeout
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= S_IDLE;
            r_adc_start <= 1'b0;
            r_tmo       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_state     <= S_START;
                        r_adc_start <= 1'b1;
                    end
                end
                S_START: begin
                    r_adc_start <= 1'b0;
                    r_tmo       <= '0;
                    r_state     <= S_CONV;
                end
                S_CONV: begin
                    if (adc_done || (r_tmo == c_tmo_max)) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_adc_start <= 1'b0;
                end
            endcase
        end
    end

    // Register file: control writes, sample capture and sticky flags (set beats clear)
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_en       <= 1'b0;
            r_pid_en   <= 1'b0;
            r_period   <= '0;
            r_overrun  <= 1'b0;
            r_timeout  <= 1'b0;
            r_dvalid   <= 1'b0;
            r_pid_drop <= 1'b0;
            r_data     <= '0;
            r_count    <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= PWDATA[CTRL_EN];
                r_pid_en <= PWDATA[CTRL_PID_EN];
            end
            if (w_wr && (w_idx == REG_PERIOD)) begin
                r_period <= PWDATA[PER_W-1:0];
            end
            if (w_overrun) begin
                r_overrun <= 1'b1;
            end else if (w_wr_stat && PWDATA[STAT_OVERRUN]) begin
                r_overrun <= 1'b0;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end else if (w_wr_stat && PWDATA[STAT_TIMEOUT]) begin
                r_timeout <= 1'b0;
            end
            if (w_drop) begin
                r_pid_drop <= 1'b1;
            end else if (w_wr_stat && PWDATA[STAT_PID_DROP]) begin
                r_pid_drop <= 1'b0;
            end
            if (w_sample) begin
                r_data   <= adc_data;
                r_dvalid <= 1'b1;
                r_count  <= r_count + 16'd1;
            end else if (w_rd && (w_idx == REG_DATA)) begin
                r_dvalid <= 1'b0;
            end
        end
    end

    // PID output register: a new push always overwrites, a handshake empties
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_pid_valid <= 1'b0;
            r_pid_data  <= '0;
        end else if (w_push) begin
            r_pid_valid <= 1'b1;
            r_pid_data  <= adc_data;
        end else if (r_pid_valid && pid_ready) begin
            r_pid_valid <= 1'b0;
        end
    end

    // APB read mux, decoded on the word offset only
    always_comb begin
        PRDATA = '0;
        case (w_idx)
            REG_CTRL: begin
                PRDATA[CTRL_EN]     = r_en;
                PRDATA[CTRL_PID_EN] = r_pid_en;
            end
            REG_PERIOD: PRDATA[PER_W-1:0] = r_period;
            REG_STATUS: begin
                PRDATA[STAT_BUSY]     = (r_state != S_IDLE);
                PRDATA[STAT_OVERRUN]  = r_overrun;
                PRDATA[STAT_TIMEOUT]  = r_timeout;
                PRDATA[STAT_DVALID]   = r_dvalid;
                PRDATA[STAT_PID_DROP] = r_pid_drop;
            end
            REG_DATA:  PRDATA[DATA_W-1:0] = r_data;
            REG_COUNT: PRDATA[15:0]       = r_count;
            default:   PRDATA = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/adc_seq_ctrl.md
# adc_seq_ctrl

APB-programmable conversion sequencer for the 12-bit ADC path. It generates periodic or one-shot conversion starts and waits for the converter's done strobe, with a timeout. Each result is latched for APB readback and pushed to the PID loop through a valid/ready port. It sits between the APB bus and the ADC front end, and is the only block that drives the converter's start line.

## Interface
- DATA_W, 12, ADC sample width
- PER_W, 16, period register width
- TMO_CYC, 255, max cycles in CONV before timeout (8-bit counter)

- PCLK  in  1  APB clock; all logic on rising edge
- PRESETn  in  1  reset, asynchronous, active-low
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB write
- PADDR  in  32  byte address; only [4:2] decoded
- PWDATA  in  32  write data
- PRDATA  out  32  read data, combinational mux on PADDR[4:2]
- PREADY  out  1  tied 1
- PSLVERR  out  1  tied 0
- adc_start  out  1  one-cycle conversion start pulse
- adc_done  in  1  one-cycle conversion complete strobe
- adc_data  in  DATA_W  result, valid when adc_done=1
- pid_valid  out  1  sample available to PID
- pid_data  out  DATA_W  sample to PID
- pid_ready  in  1  PID accepts sample

## Operation
- A register write takes effect when PSEL & PENABLE & PWRITE. A read side effect takes effect when PSEL & PENABLE & ~PWRITE. Unmapped offsets read 0; writes to them are ignored.
- 0x00 CTRL, RW:
  - [0] en.
  - [1] oneshot. Write-1 produces a single trigger. This bit is self-clearing and reads 0.
  - [2] pid_en.
- 0x04 PERIOD, RW, [PER_W-1:0].
- 0x08 STATUS:
  - [0] busy, RO. 1 when the FSM is not in IDLE.
  - [1] overrun, W1C.
  - [2] timeout, W1C.
  - [3] data_valid, RO.
  - [4] pid_drop, W1C.
- 0x0C DATA, RO, [DATA_W-1:0]. Holds the last sample. Reading it clears data_valid.
- 0x10 COUNT, RO, 16-bit. Counts completed samples and wraps from 0xFFFF to 0.
- Timer:
  - A write of en=1 (from en=0) loads the down-counter with PERIOD.
  - While en=1 the counter decrements each cycle. At 0 it emits a one-cycle tick and reloads PERIOD. Ticks therefore occur every PERIOD+1 cycles.
  - en=0 freezes the counter.
- Trigger: tick OR oneshot write. If both occur in the same cycle, this is one trigger.
- FSM states: IDLE, START, CONV.
  - IDLE: on a trigger, go to START.
  - START: adc_start=1 for exactly 1 cycle, then go to CONV and clear the timeout counter.
  - CONV, on adc_done: latch adc_data into DATA, set data_valid, increment COUNT, push to PID if pid_en, then go to IDLE.
  - CONV, on timeout: if the timeout counter reaches TMO_CYC without adc_done, set the timeout flag and go to IDLE. DATA and COUNT are unchanged.
- A trigger while the FSM is not in IDLE is dropped and sets overrun.
- adc_done outside CONV is ignored.
- Clearing en mid-conversion does not abort the conversion; CONV completes normally.
- PID port:
  - A push sets pid_valid=1 and pid_data=sample. The pair holds until pid_valid & pid_ready.
  - A push while pid_valid & ~pid_ready overwrites pid_data and sets pid_drop.
  - A push in the same cycle as a handshake loads the new sample with no drop.
  - pid_en=0 suppresses new pushes but leaves a pending sample valid.
- Sticky flags: if a set event and a W1C occur in the same cycle, set wins.
- If a DATA read coincides with a new sample, data_valid ends at 1.

## Timing
- Reset values:
  - adc_start=0, pid_valid=0, pid_data=0, PRDATA reflects zeroed registers.
  - All registers 0, FSM in IDLE, timer counter 0.
- Trigger in cycle T, FSM in IDLE: START in T+1, so adc_start=1 in T+1. CONV from T+2.
- adc_done in cycle D: DATA, COUNT, data_valid and pid_valid are updated and visible from D+1; the FSM is in IDLE in D+1.
- Minimum trigger-to-trigger spacing without overrun: 3 + converter latency cycles.
- Timeout: the flag sets TMO_CYC cycles after entering CONV; the FSM is in IDLE the next cycle.
- PRESETn asserted mid-operation:
  - The FSM immediately returns to IDLE and adc_start drops to 0.
  - Any pending PID sample is discarded.

## Structure
- Package adc_seq_pkg contains:
  - the state enum (IDLE, START, CONV);
  - register offset constants (CTRL, PERIOD, STATUS, DATA, COUNT);
  - CTRL and STATUS bit-position constants.
- Sub-module adc_seq_timer contains the period down-counter and tick generation. Its inputs are en, the en-rise load, and PERIOD; its output is tick.
- The register file, FSM and PID output register reside in adc_seq_ctrl.

## Test plan
- Periodic mode:
  - Stimulus: PERIOD=9, en=1, converter done 4 cycles after adc_start.
  - Required: adc_start every 10 cycles; COUNT=5 after 5 ticks; DATA equals the last adc_data; overrun=0.
- Overrun:
  - Stimulus: PERIOD=2, converter latency 8.
  - Required: overrun=1 and triggers dropped; a W1C clears overrun; a W1C coincident with a new overrun leaves the flag at 1.
- Timeout:
  - Stimulus: oneshot, adc_done never asserted.
  - Required: timeout=1 exactly TMO_CYC cycles after entering CONV; COUNT unchanged; busy=0 the next cycle.
- PID backpressure:
  - Stimulus: pid_en=1, pid_ready=0 across two samples 0x123 then 0x456.
  - Required: pid_data=0x456, pid_drop=1; with pid_ready=1, one handshake and pid_valid=0.
- Mid-operation events:
  - Stimulus: en cleared during CONV.
  - Required: the conversion completes and COUNT increments; no further ticks.
  - Stimulus: PRESETn pulsed during CONV.
  - Required: all outputs return to reset values; a late adc_done is ignored.
